fifo_stream_reader: RTL
=======================

Name: fifo_stream_reader

Overview:
- Read-side master for the team's synchronous FIFO (i_wren/i_rden, o_full/o_empty/o_alm_empty/o_rddata).
- Pops FIFO entries in bursts and hides the FIFO's 1-cycle registered read latency with a 2-entry skid buffer.
- Presents the data downstream as a valid/ready stream.
- Sits between the FIFO read port and any consumer that may stall.

Parameters:
- WIDTH, 128, data width; must match the FIFO WIDTH.
- BURST_LEN, 4, max pops per burst (1..15).
- TIMEOUT, 16, idle cycles with FIFO non-empty before a partial burst is forced (≥1).
- CNT_W, 16, width of the popped-word counter.

Ports:
- clk  input  1  single clock, rising edge.
- rstn  input  1  reset, asynchronous and active-high (asserted = 1 clears all state).
- o_rden  output  1  read strobe to FIFO i_rden.
- i_empty  input  1  FIFO o_empty.
- i_alm_empty  input  1  FIFO o_alm_empty.
- i_rddata  input  WIDTH  FIFO o_rddata; valid the cycle after an accepted o_rden.
- o_tdata  output  WIDTH  downstream data.
- o_tvalid  output  1  downstream valid.
- i_tready  input  1  downstream ready.
- o_busy  output  1  FSM not in IDLE, or buffer/in-flight non-empty.
- o_pop_cnt  output  CNT_W  total FIFO pops issued; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rstn=1, async):
  - FSM=IDLE; skid buffer empty; in-flight flag=0; burst count=0; timeout count=0.
  - o_rden=0, o_tvalid=0, o_tdata=0, o_busy=0, o_pop_cnt=0.
- o_rden is combinational from state, i_empty and credit. No pop is ever issued when i_empty=1.
- Credit rule:
  - Pop allowed only if (buffered entries + in-flight) < 2.
  - In-flight is set on a pop cycle and cleared the next cycle, when i_rddata is written into the buffer.
  - Buffer never overflows, even with i_tready held low indefinitely.
- Skid buffer:
  - 2-entry FIFO: head drives o_tdata, o_tvalid = buffer non-empty.
  - Transfer occurs when o_tvalid & i_tready; the head is removed that cycle.
  - Same-cycle write from in-flight and transfer: occupancy unchanged, order preserved.
  - o_tdata is held stable while o_tvalid=1 and i_tready=0.
- FSM:
  - IDLE:
    - timeout count increments while i_empty=0; clears when i_empty=1.
    - Go to BURST when i_alm_empty=0, or timeout count == TIMEOUT-1 and i_empty=0. Clear burst count.
  - BURST:
    - Each issued pop increments burst count.
    - Go to IDLE (timeout count cleared) after the pop that makes burst count == BURST_LEN, or when i_empty=1 on any cycle.
    - A stalled downstream (no credit) holds BURST without popping.
- Latency:
  - First o_rden is the cycle after the IDLE→BURST transition.
  - o_tvalid rises 2 cycles after that o_rden: 1 cycle FIFO read, 1 cycle buffer write.
  - Sustained throughput is 1 word/cycle while i_tready=1 and the FIFO is non-empty.
- o_pop_cnt increments on every o_rden=1 cycle; 2^CNT_W-1 → 0.
- o_busy = (state != IDLE) | in-flight | buffer non-empty.
- Reset mid-burst: in-flight data arriving after reset release is discarded, not buffered.

Decomposition:
- Shared package fifo_pkg:
  - localparams for the default WIDTH/DEPTH/ADDRESS.
  - typedef enum logic [0:0] {RD_IDLE, RD_BURST} rd_state_t.
  - Default BURST_LEN and TIMEOUT constants.
- One sub-module, fifo_skid_buf:
  - 2-entry valid/ready buffer with write port, head output and occupancy output.
  - Reused by later stream blocks.
- The FSM, counters and credit logic stay in fifo_stream_reader.

Test Plan:
- Reset then 8 words 0x1..0x8 loaded (i_alm_empty=0), i_tready=1 → BURST of 4 pops, tdata 0x1..0x4 in order; 2nd burst yields 0x5..0x8; o_pop_cnt=8.
- 2 words (i_alm_empty=1, i_empty=0), TIMEOUT=16 → first o_rden exactly 16 cycles after i_empty fell; tdata 0x1, 0x2; return to IDLE when i_empty=1.
- i_tready=0 with 10 words available → exactly 2 pops, o_tvalid=1 with o_tdata=0x1 held stable; releasing i_tready gives a gap-free 0x1,0x2,0x3….
- i_tready toggling 1/0 every cycle over 12 words → no loss or duplication; order 0x1..0xC; o_rden never asserted with i_empty=1.
- Preload o_pop_cnt to 2^CNT_W-2 via a 2-pop stimulus (CNT_W=2 build) → count wraps 3→0.
- rstn asserted mid-burst with in-flight data → all outputs 0 asynchronously; no stale word appears on o_tdata after release.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and types for the synchronous FIFO and its stream-side helpers.
package fifo_pkg;

  // Default geometry of the team FIFO.
  localparam int FIFO_WIDTH   = 128;
  localparam int FIFO_DEPTH   = 16;
  localparam int FIFO_ADDRESS = 4;

  // Default read-master tuning.
  localparam int RD_BURST_LEN = 4;
  localparam int RD_TIMEOUT   = 16;

  typedef enum logic [0:0] {
    RD_IDLE  = 1'b0,
    RD_BURST = 1'b1
  } rd_state_t;

  // A new pop may issue when the skid buffer, after this cycle's transfer,
  // plus the word already in flight from the FIFO leaves room for one more.
  function automatic logic rd_has_credit(input logic [1:0] occ,
                                         input logic       xfer,
                                         input logic       in_flight);
    logic [1:0] eff;
    eff = occ - {1'b0, xfer} + {1'b0, in_flight};
    return (eff < 2'd2);
  endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry valid/ready skid buffer: slot 0 is the head, slot 1 the tail.
// A write arriving while the head leaves keeps occupancy and order intact.
module fifo_skid_buf #(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic [1:0]       occ
);

  logic [WIDTH-1:0] slot_q [2];
  logic [WIDTH-1:0] slot_d [2];
  logic [1:0]       occ_q;
  logic [1:0]       occ_d;
  logic             pop;
  logic             push;

  // The head only leaves when present; a write into a full buffer with no
  // departure is dropped (the reader's credit check never lets that happen).
  assign pop  = rd_en && (occ_q != 2'd0);
  assign push = wr_en && ((occ_q != 2'd2) || pop);

  // Next slot contents and occupancy from the push/pop combination.
  always_comb begin
    slot_d[0] = slot_q[0];
    slot_d[1] = slot_q[1];
    occ_d     = occ_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) slot_d[0] = wr_data;
        else               slot_d[1] = wr_data;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        slot_d[0] = slot_q[1];
        occ_d     = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          slot_d[0] = wr_data;
        end else begin
          slot_d[0] = slot_q[1];
          slot_d[1] = wr_data;
        end
      end
      default: ;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      // Slot storage register.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) slot_q[gi] <= '0;
        else     slot_q[gi] <= slot_d[gi];
      end
    end
  endgenerate

  // Occupancy register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) occ_q <= 2'd0;
    else     occ_q <= occ_d;
  end

  assign head_valid = (occ_q != 2'd0);
  assign head_data  = head_valid ? slot_q[0] : '0;
  assign occ        = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side master for the synchronous FIFO: pops in bursts, absorbs the
// FIFO's one-cycle read latency in a skid buffer, and streams valid/ready.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int WIDTH     = FIFO_WIDTH,
  parameter int BURST_LEN = RD_BURST_LEN,
  parameter int TIMEOUT   = RD_TIMEOUT,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rstn,
  output logic             o_rden,
  input  logic             i_empty,
  input  logic             i_alm_empty,
  input  logic [WIDTH-1:0] i_rddata,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tvalid,
  input  logic             i_tready,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_pop_cnt
);

  localparam int              TO_W       = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT - 1);
  localparam logic [3:0]      BURST_LAST = 4'(BURST_LEN);

  rd_state_t        state_q, state_d;
  logic             infl_q, infl_d;
  logic [3:0]       burst_cnt_q, burst_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0] pop_cnt_q, pop_cnt_d;

  logic [1:0]       buf_occ;
  logic             xfer;
  logic             credit;
  logic             pop;

  // The word popped last cycle lands in the buffer this cycle; a word whose
  // pop predates a reset is ignored because reset clears the in-flight flag.
  fifo_skid_buf #(.WIDTH(WIDTH)) u_skid (
    .clk        (clk),
    .rst        (rstn),
    .wr_en      (infl_q),
    .wr_data    (i_rddata),
    .rd_en      (i_tready),
    .head_data  (o_tdata),
    .head_valid (o_tvalid),
    .occ        (buf_occ)
  );

  assign xfer   = o_tvalid && i_tready;
  assign credit = rd_has_credit(buf_occ, xfer, infl_q);
  assign pop    = (state_q == RD_BURST) && !i_empty && credit;
  assign o_rden = pop;

  // Burst FSM with idle timeout and per-burst pop counting.
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    to_cnt_d    = to_cnt_q;
    case (state_q)
      RD_IDLE: begin
        to_cnt_d = i_empty ? '0 : to_cnt_q + 1'b1;
        if (!i_alm_empty || (!i_empty && (to_cnt_q == TO_LAST))) begin
          state_d     = RD_BURST;
          burst_cnt_d = 4'd0;
          to_cnt_d    = '0;
        end
      end
      RD_BURST: begin
        to_cnt_d = '0;
        if (pop) burst_cnt_d = burst_cnt_q + 4'd1;
        if (i_empty || (pop && ((burst_cnt_q + 4'd1) == BURST_LAST)))
          state_d = RD_IDLE;
      end
      default: state_d = RD_IDLE;
    endcase
  end

  // In-flight flag and wrapping pop counter.
  always_comb begin
    infl_d    = pop;
    pop_cnt_d = pop_cnt_q + CNT_W'(pop);
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q     <= RD_IDLE;
      infl_q      <= 1'b0;
      burst_cnt_q <= 4'd0;
      to_cnt_q    <= '0;
      pop_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      infl_q      <= infl_d;
      burst_cnt_q <= burst_cnt_d;
      to_cnt_q    <= to_cnt_d;
      pop_cnt_q   <= pop_cnt_d;
    end
  end

  assign o_busy    = (state_q != RD_IDLE) || infl_q || (buf_occ != 2'd0);
  assign o_pop_cnt = pop_cnt_q;

endmodule
